ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage RV32I pipeline: selects ALU operands using the `forwardA`/`forwardB` codes from the forwarding unit, executes the ALU/branch/jump operation for the instruction in EX, and loads the EX/MEM pipeline register. The block also produces the fetch redirect for taken branches and jumps. Its registered outputs `idata_MEM` and `regwrite_MEM` feed straight back into the forwarding unit.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `RESET_NOP`, 32'h00000013, bubble instruction word (`addi x0,x0,0`; rd = 0).

- `clk`, input, 1, pipeline clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `stall`, input, 1, freeze: the EX/MEM register holds its value.
- `flush`, input, 1, load a bubble into EX/MEM.
- `valid_EX`, input, 1, EX holds a real instruction.
- `idata_EX`, input, 32, instruction word in EX.
- `pc_EX`, input, 32, PC of the instruction in EX.
- `rs1_data_EX` / `rs2_data_EX`, input, 32 each, register-file read data from ID/EX.
- `imm_EX`, input, 32, sign-extended immediate from decode.
- `regwrite_EX` / `memread_EX` / `memwrite_EX`, input, 1 each, control signals from ID/EX.
- `forwardA` / `forwardB`, input, 2 each, operand source select:
  - 00: register file
  - 10: `alu_result_MEM`
  - 01: `wb_data_WB`
  - 11: treated as 00
- `wb_data_WB`, input, 32, write-back value.
- `idata_MEM`, output, 32, registered instruction word.
- `pc_MEM`, output, 32, registered PC.
- `alu_result_MEM`, output, 32, registered ALU result or link address.
- `store_data_MEM`, output, 32, registered forwarded rs2.
- `regwrite_MEM` / `memread_MEM` / `memwrite_MEM` / `valid_MEM`, output, 1 each, registered control signals.
- `redirect`, output, 1, combinational; take the branch or jump now.
- `redirect_pc`, output, 32, combinational; target address.

## Operation
**Opcode** is `idata_EX[6:0]`.

**Operands.**
- `fa` = rs1 after the forward mux; `fb` = rs2 after the forward mux.
- `store_data` = `fb`.
- opA:
  - LUI: 0
  - AUIPC, JAL: `pc_EX`
  - all other opcodes: `fa`
- opB:
  - OP (0110011), BRANCH: `fb`
  - all other opcodes: `imm_EX`

**ALU.** Function is set by funct3 (`idata_EX[14:12]`) for OP and OP-IMM.
- Supported functions: ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
- SUB is selected only for OP with `idata_EX[30]` = 1.
- SRA is selected when `idata_EX[30]` = 1, for both OP and OP-IMM.
- Shift amount is `opB[4:0]`.
- SLT is signed and SLTU is unsigned; both give a 0/1 result.
- All arithmetic wraps modulo 2^32; there is no overflow flag.
- LOAD, STORE, LUI, AUIPC use ADD.
- JAL and JALR produce `pc_EX`+4.
- Unsupported opcodes produce result 0 and never redirect.

**Branch compare.** Operates on `fa`/`fb` by funct3:
- 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
- funct3 010 and 011 are never taken.

**Redirect.**
- `redirect` = `valid_EX` & ~`stall` & (JAL | JALR | taken BRANCH).
- `redirect_pc`:
  - JAL, BRANCH: `pc_EX`+`imm_EX`
  - JALR: (`fa`+`imm_EX`) & ~1

**EX/MEM register** update priority, highest first:
1. `flush`, or ~`valid_EX` when not stalled: load a bubble.
   - `idata_MEM` = `RESET_NOP`.
   - `valid_MEM`, `regwrite_MEM`, `memread_MEM`, `memwrite_MEM` = 0.
   - `alu_result_MEM`, `store_data_MEM`, `pc_MEM` = 0.
2. `stall`: hold all registers.
3. Otherwise: load the EX results and the pass-through control signals; `valid_MEM` = 1.

## Timing
- Reset (async assert, sync release by `rst_n` rising before a `clk` edge): every registered output takes its bubble value. `idata_MEM` = 32'h00000013; all other registered outputs are 0.
- EX-to-MEM latency is 1 cycle: values computed in cycle n are visible in cycle n+1.
- `redirect` and `redirect_pc` are combinational from the EX inputs in the same cycle. The hazard unit asserts `flush` for the younger stages; this block does not self-flush.
- `flush` and `stall` together: flush wins.
- A redirect is suppressed while `stall` = 1 and is presented again once `stall` drops (the EX contents are unchanged).
- Forward mux paths are combinational from `alu_result_MEM`/`wb_data_WB`; the MEM-stage path must close in one cycle together with the ALU.
- Reset asserted mid-stall or mid-flush: bubble state immediately; no pending redirect survives.

## Test plan
- **ADD with forwarding.** x1=5 in the regfile; `alu_result_MEM`=7; `forwardA`=10; `rs2_data_EX`=3; `forwardB`=00; add x3,x1,x2. Next cycle: `alu_result_MEM`=10, `regwrite_MEM`=1, `idata_MEM`[11:7]=3.
- **Shift and SUB.** SRA with `fa`=32'h80000000, `fb`=4 → 32'hF8000000. SUB with 0-1 → 32'hFFFFFFFF.
- **BLT.** `fa`=-1, `fb`=1, `pc_EX`=32'h100, `imm_EX`=-8. `redirect`=1 and `redirect_pc`=32'hF8 in the same cycle; the BLTU variant gives `redirect`=0.
- **JALR.** `fa`=32'h2001, `imm_EX`=2, `pc_EX`=32'h40. `redirect_pc`=32'h2002; next cycle `alu_result_MEM`=32'h44.
- **Stall then flush.** Stall 3 cycles: EX/MEM is held and `redirect`=0. Then assert `flush` together with `stall`: next edge gives `idata_MEM`=32'h13 and `valid_MEM`=`regwrite_MEM`=0.
- **Async reset.** Drop `rst_n` between clock edges with a live instruction in MEM: outputs go to reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with operand forwarding, ALU, branch resolve and EX/MEM register
module ex_stage #(
  parameter int XLEN = 32,
  parameter logic [31:0] RESET_NOP = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_EX,
  input  logic [31:0]     idata_EX,
  input  logic [XLEN-1:0] pc_EX,
  input  logic [XLEN-1:0] rs1_data_EX,
  input  logic [XLEN-1:0] rs2_data_EX,
  input  logic [XLEN-1:0] imm_EX,
  input  logic            regwrite_EX,
  input  logic            memread_EX,
  input  logic            memwrite_EX,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] wb_data_WB,
  output logic [31:0]     idata_MEM,
  output logic [XLEN-1:0] pc_MEM,
  output logic [XLEN-1:0] alu_result_MEM,
  output logic [XLEN-1:0] store_data_MEM,
  output logic            regwrite_MEM,
  output logic            memread_MEM,
  output logic            memwrite_MEM,
  output logic            valid_MEM,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  typedef struct packed {
    logic [31:0]     idata;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            v;
  } mem_t;
  localparam mem_t BUBBLE = '{RESET_NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_op, is_opi, is_jal, is_jalr, is_br, taken;
  logic [XLEN-1:0] fa, fb, opa, opb, alu, sra, res;
  logic [4:0] sh;
  mem_t mem_d, mem_q;
  assign opc = idata_EX[6:0];
  assign f3 = idata_EX[14:12];
  assign is_op = opc == OP;
  assign is_opi = opc == OPI;
  assign is_jal = opc == JAL;
  assign is_jalr = opc == JALR;
  assign is_br = opc == BR;
  // operand forwarding, ALU, and branch comparison
  always_comb begin
    fa = forwardA == 2'b10 ? alu_result_MEM : forwardA == 2'b01 ? wb_data_WB : rs1_data_EX;
    fb = forwardB == 2'b10 ? alu_result_MEM : forwardB == 2'b01 ? wb_data_WB : rs2_data_EX;
    opa = opc == LUI ? '0 : (opc == AUIPC || is_jal) ? pc_EX : fa;
    opb = (is_op || is_br) ? fb : imm_EX;
    sh = opb[4:0];
    sra = $signed(opa) >>> sh;
    case (f3)
      3'b000:  alu = (is_op && idata_EX[30]) ? opa - opb : opa + opb;
      3'b001:  alu = opa << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, opa < opb};
      3'b100:  alu = opa ^ opb;
      3'b101:  alu = idata_EX[30] ? sra : opa >> sh;
      3'b110:  alu = opa | opb;
      default: alu = opa & opb;
    endcase
    res = (is_op || is_opi) ? alu :
          (opc == LD || opc == ST || opc == LUI || opc == AUIPC) ? opa + opb :
          (is_jal || is_jalr) ? pc_EX + XLEN'(4) : '0;
    case (f3)
      3'b000:  taken = fa == fb;
      3'b001:  taken = fa != fb;
      3'b100:  taken = $signed(fa) < $signed(fb);
      3'b101:  taken = $signed(fa) >= $signed(fb);
      3'b110:  taken = fa < fb;
      3'b111:  taken = fa >= fb;
      default: taken = 1'b0;
    endcase
  end
  assign redirect = valid_EX & ~stall & (is_jal | is_jalr | (is_br & taken));
  assign redirect_pc = is_jalr ? (fa + imm_EX) & ~XLEN'(1) : pc_EX + imm_EX;
  // EX/MEM next state: bubble beats hold beats load
  always_comb begin
    mem_d = (flush || (!valid_EX && !stall)) ? BUBBLE :
            stall ? mem_q :
            mem_t'{idata_EX, pc_EX, res, fb, regwrite_EX, memread_EX, memwrite_EX, 1'b1};
  end
  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= BUBBLE;
    else mem_q <= mem_d;
  end
  assign idata_MEM = mem_q.idata;
  assign pc_MEM = mem_q.pc;
  assign alu_result_MEM = mem_q.alu;
  assign store_data_MEM = mem_q.sd;
  assign regwrite_MEM = mem_q.rw;
  assign memread_MEM = mem_q.mr;
  assign memwrite_MEM = mem_q.mw;
  assign valid_MEM = mem_q.v;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage against a behavioural RV32I execute model
module tb_ex_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall = 0, flush = 0, valid_EX = 0, regwrite_EX = 0, memread_EX = 0, memwrite_EX = 0;
  logic [31:0] idata_EX = 0, pc_EX = 0, rs1_data_EX = 0, rs2_data_EX = 0, imm_EX = 0, wb_data_WB = 0;
  logic [1:0] forwardA = 0, forwardB = 0;
  logic [31:0] idata_MEM, pc_MEM, alu_result_MEM, store_data_MEM, redirect_pc;
  logic regwrite_MEM, memread_MEM, memwrite_MEM, valid_MEM, redirect;
  logic go = 1'b0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_EX(valid_EX),
    .idata_EX(idata_EX), .pc_EX(pc_EX), .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX),
    .imm_EX(imm_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX), .memwrite_EX(memwrite_EX),
    .forwardA(forwardA), .forwardB(forwardB), .wb_data_WB(wb_data_WB),
    .idata_MEM(idata_MEM), .pc_MEM(pc_MEM), .alu_result_MEM(alu_result_MEM),
    .store_data_MEM(store_data_MEM), .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
    .memwrite_MEM(memwrite_MEM), .valid_MEM(valid_MEM), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] idata, pc, alu, sd;
    logic rw, mr, mw, v;
  } mrec_t;
  typedef struct {
    logic r;
    logic [31:0] pc;
  } rrec_t;

  mrec_t mq[$];
  rrec_t rq[$];
  mrec_t m;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endfunction

  function automatic mrec_t bubble();
    mrec_t b;
    b.idata = 32'h13; b.pc = 0; b.alu = 0; b.sd = 0;
    b.rw = 0; b.mr = 0; b.mw = 0; b.v = 0;
    return b;
  endfunction

  function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] rf, logic [31:0] mv, logic [31:0] wv);
    if (s == 2'b10) return mv;
    if (s == 2'b01) return wv;
    return rf;
  endfunction

  function automatic logic [31:0] model_res(logic [31:0] id, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
    int unsigned s;
    logic [6:0] o;
    s = b[4:0];
    o = id[6:0];
    case (o)
      7'b0110011, 7'b0010011:
        case (id[14:12])
          3'd0: return (o == 7'b0110011 && id[30]) ? a - b : a + b;
          3'd1: return a << s;
          3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          3'd3: return (a < b) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: return id[30] ? ((a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0)) : a >> s;
          3'd6: return a | b;
          default: return a & b;
        endcase
      7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111: return a + b;
      7'b1101111, 7'b1100111: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic st, input logic fl, input logic vl, input logic [31:0] id,
                      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [1:0] fwa, input logic [1:0] fwb,
                      input logic [31:0] wb, input logic rw, input logic mr, input logic mw);
    logic [31:0] a, b, oa, ob;
    logic [6:0] o;
    rrec_t rr;
    mrec_t n;
    @(negedge clk);
    stall = st; flush = fl; valid_EX = vl; idata_EX = id; pc_EX = pc;
    rs1_data_EX = r1; rs2_data_EX = r2; imm_EX = im; forwardA = fwa; forwardB = fwb;
    wb_data_WB = wb; regwrite_EX = rw; memread_EX = mr; memwrite_EX = mw;
    o = id[6:0];
    a = fwd(fwa, r1, m.alu, wb);
    b = fwd(fwb, r2, m.alu, wb);
    oa = (o == 7'b0110111) ? 32'd0 : (o == 7'b0010111 || o == 7'b1101111) ? pc : a;
    ob = (o == 7'b0110011 || o == 7'b1100011) ? b : im;
    rr.r = vl && !st && (o == 7'b1101111 || o == 7'b1100111 || (o == 7'b1100011 && model_taken(id[14:12], a, b)));
    rr.pc = (o == 7'b1100111) ? ((a + im) & 32'hFFFFFFFE) : pc + im;
    rq.push_back(rr);
    if (fl || (!vl && !st)) m = bubble();
    else if (!st) begin
      n.idata = id; n.pc = pc; n.alu = model_res(id, pc, oa, ob); n.sd = b;
      n.rw = rw; n.mr = mr; n.mw = mw; n.v = 1'b1;
      m = n;
    end
    mq.push_back(m);
  endtask

  // monitor: redirect before each edge, EX/MEM after each edge
  initial begin
    rrec_t rr;
    mrec_t e;
    wait (go);
    forever begin
      @(negedge clk);
      #4;
      if (rq.size() > 0) begin
        rr = rq.pop_front();
        chk("redirect", {31'b0, redirect}, {31'b0, rr.r});
        if (rr.r) chk("redirect_pc", redirect_pc, rr.pc);
      end
      @(posedge clk);
      #1;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        chk("idata_MEM", idata_MEM, e.idata);
        chk("pc_MEM", pc_MEM, e.pc);
        chk("alu_result_MEM", alu_result_MEM, e.alu);
        chk("store_data_MEM", store_data_MEM, e.sd);
        chk("ctl_MEM", {28'b0, regwrite_MEM, memread_MEM, memwrite_MEM, valid_MEM}, {28'b0, e.rw, e.mr, e.mw, e.v});
      end
    end
  end

  initial begin
    logic [6:0] opcs [10];
    logic [31:0] id, r1, r2;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1111111};
    #12;
    chk("reset idata_MEM", idata_MEM, 32'h13);
    chk("reset pc_MEM", pc_MEM, 0);
    chk("reset alu_result_MEM", alu_result_MEM, 0);
    chk("reset store_data_MEM", store_data_MEM, 0);
    chk("reset ctl_MEM", {28'b0, regwrite_MEM, memread_MEM, memwrite_MEM, valid_MEM}, 0);
    m = bubble();
    @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
    step(0, 0, 1, 32'h00700293, 32'h0, 0, 0, 7, 2'b00, 2'b00, 0, 1, 0, 0);
    step(0, 0, 1, 32'h002081B3, 32'h4, 5, 3, 0, 2'b10, 2'b00, 0, 1, 0, 0);
    @(posedge clk); #2;
    chk("add fwd result", alu_result_MEM, 10);
    chk("add fwd regwrite", {31'b0, regwrite_MEM}, 1);
    chk("add fwd rd", {27'b0, idata_MEM[11:7]}, 3);
    step(0, 0, 1, 32'h4020D233, 32'h8, 32'h80000000, 4, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    @(posedge clk); #2;
    chk("sra result", alu_result_MEM, 32'hF8000000);
    step(0, 0, 1, 32'h40208233, 32'hC, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    @(posedge clk); #2;
    chk("sub result", alu_result_MEM, 32'hFFFFFFFF);
    step(0, 0, 1, 32'h0020C063, 32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 2'b00, 2'b00, 0, 0, 0, 0);
    #3;
    chk("blt redirect", {31'b0, redirect}, 1);
    chk("blt target", redirect_pc, 32'hF8);
    step(0, 0, 1, 32'h0020E063, 32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 2'b00, 2'b00, 0, 0, 0, 0);
    #3;
    chk("bltu redirect", {31'b0, redirect}, 0);
    step(0, 0, 1, 32'h002080E7, 32'h40, 32'h2001, 0, 2, 2'b00, 2'b00, 0, 1, 0, 0);
    #3;
    chk("jalr target", redirect_pc, 32'h2002);
    @(posedge clk); #2;
    chk("jalr link", alu_result_MEM, 32'h44);
    step(0, 0, 1, 32'h008000EF, 32'h80, 0, 0, 8, 2'b00, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 32'h008000EF, 32'h80, 0, 0, 8, 2'b00, 2'b00, 0, 1, 0, 0);
      #3;
      chk("stall redirect", {31'b0, redirect}, 0);
      @(posedge clk); #2;
      chk("stall hold", alu_result_MEM, 32'h84);
    end
    step(1, 1, 1, 32'h008000EF, 32'h80, 0, 0, 8, 2'b00, 2'b00, 0, 1, 0, 0);
    @(posedge clk); #2;
    chk("flush idata", idata_MEM, 32'h13);
    chk("flush valid/regwrite", {30'b0, valid_MEM, regwrite_MEM}, 0);
    step(0, 0, 1, 32'h008000EF, 32'h80, 0, 0, 8, 2'b00, 2'b00, 0, 1, 0, 0);
    #3;
    chk("redirect after stall", {31'b0, redirect}, 1);
    for (int i = 0; i < 400; i++) begin
      id = $urandom;
      id[6:0] = opcs[$urandom_range(0, 9)];
      r1 = ($urandom_range(0, 3) == 0) ? 32'(-$urandom_range(0, 4)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
           id, $urandom, r1, r2, $urandom, 2'($urandom), 2'($urandom), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    step(0, 0, 1, 32'h00700293, 32'h200, 0, 0, 7, 2'b00, 2'b00, 0, 1, 0, 0);
    @(posedge clk); #3;
    chk("live before reset", {31'b0, valid_MEM}, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset idata", idata_MEM, 32'h13);
    chk("async reset alu", alu_result_MEM, 0);
    chk("async reset pc", pc_MEM, 0);
    chk("async reset ctl", {28'b0, regwrite_MEM, memread_MEM, memwrite_MEM, valid_MEM}, 0);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
